// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA modular exponentiation datapath.
// Holds the one-hot engine state encoding, multiplier latency and error codes.
package rsa_pkg;

    typedef enum logic [7:0] {
        S_IDLE  = 8'b0000_0001,
        S_CHECK = 8'b0000_0010,
        S_TOM_X = 8'b0000_0100,
        S_TOM_1 = 8'b0000_1000,
        S_SQ    = 8'b0001_0000,
        S_MUL   = 8'b0010_0000,
        S_FROMM = 8'b0100_0000,
        S_DONE  = 8'b1000_0000
    } state_t;

    localparam logic ERR_NONE    = 1'b0;
    localparam logic ERR_OPERAND = 1'b1;

    // Cycles from a multiplier start pulse to its done pulse.
    function automatic int mm_latency(input int w);
        return w + 2;
    endfunction

endpackage

// File: rtl/mont_mult.sv
// Radix-2 bit-serial Montgomery multiplier: s = a*b*2^-WIDTH mod m, s < m.
// Ports: clk, rst_n, start (pulse), a, b, m (odd, held), done (pulse), s.
module mont_mult
    import rsa_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    output logic             done,
    output logic [WIDTH-1:0] s
);

    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] CNT_LOAD = CW'(mm_latency(WIDTH) - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH+1:0] acc;
    logic [CW-1:0]    cnt;
    logic             run;

    logic [WIDTH+1:0] m_ext;
    logic [WIDTH+1:0] b_ext;
    logic [WIDTH+1:0] sum1;
    logic [WIDTH+1:0] sum2;
    logic [WIDTH+1:0] acc_nxt;
    logic             ge;
    logic [WIDTH-1:0] s_nxt;

    // acc stays below 2m, so acc + b + m < 4m fits in WIDTH+2 bits.
    always_comb begin
        m_ext   = {2'b00, m};
        b_ext   = {2'b00, b_q};
        sum1    = acc + (a_q[0] ? b_ext : '0);
        sum2    = sum1 + (sum1[0] ? m_ext : '0);
        acc_nxt = sum2 >> 1;
        ge      = acc >= m_ext;
        // Result is below m, so the subtraction is exact modulo 2^WIDTH.
        s_nxt   = acc[WIDTH-1:0] - (ge ? m : '0);
    end

    // cnt runs WIDTH+1 down to 2 for the WIDTH iterations, then 1 for
    // the final subtraction, giving done WIDTH+2 cycles after start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q  <= '0;
            b_q  <= '0;
            acc  <= '0;
            cnt  <= '0;
            run  <= 1'b0;
            done <= 1'b0;
            s    <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                a_q <= a;
                b_q <= b;
                acc <= '0;
                cnt <= CNT_LOAD;
                run <= 1'b1;
            end else if (run) begin
                if (cnt == CNT_ONE) begin
                    s    <= s_nxt;
                    done <= 1'b1;
                    run  <= 1'b0;
                end else begin
                    acc <= acc_nxt;
                    a_q <= a_q >> 1;
                end
                cnt <= cnt - CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/mont_modexp_engine.sv
// Montgomery modular exponentiator z = x^e mod m, left-to-right square-and-multiply.
// Ports: clk, rst_n, in_valid/in_ready + x, e, exp_len, m, r2; out_valid/out_ready + z, err; busy.
module mont_modexp_engine
    import rsa_pkg::*;
#(
    parameter int WIDTH     = 64,
    parameter int EXP_WIDTH = 64,
    localparam int LEN_W    = $clog2(EXP_WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     x,
    input  logic [EXP_WIDTH-1:0] e,
    input  logic [LEN_W-1:0]     exp_len,
    input  logic [WIDTH-1:0]     m,
    input  logic [WIDTH-1:0]     r2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     z,
    output logic                 err,
    output logic                 busy
);

    localparam logic [WIDTH-1:0]     ONE     = WIDTH'(1);
    localparam logic [EXP_WIDTH-1:0] E_ONE   = EXP_WIDTH'(1);
    localparam logic [LEN_W-1:0]     LEN_ONE = LEN_W'(1);
    localparam logic [LEN_W-1:0]     LEN_MAX = LEN_W'(EXP_WIDTH);

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0]     x_q;
    logic [EXP_WIDTH-1:0] e_q;
    logic [LEN_W-1:0]     len_q;
    logic [WIDTH-1:0]     m_q;
    logic [WIDTH-1:0]     r2_q;
    logic [WIDTH-1:0]     p_q;
    logic [WIDTH-1:0]     zr_q;
    logic [LEN_W-1:0]     i_q;
    logic                 issued;
    logic [WIDTH-1:0]     z_q;
    logic                 err_q;

    logic             mm_start;
    logic             mm_done;
    logic [WIDTH-1:0] mm_a;
    logic [WIDTH-1:0] mm_b;
    logic [WIDTH-1:0] mm_s;

    logic op_state;
    logic accept;
    logic bad_op;
    logic m_one;
    logic e_bit;
    logic i_zero;

    assign accept = in_valid && (state == S_IDLE);
    assign bad_op = !m_q[0] || (x_q >= m_q) || (len_q > LEN_MAX);
    assign m_one  = (m_q == ONE);
    assign e_bit  = |(e_q & (E_ONE << i_q));
    assign i_zero = (i_q == '0);

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);
    assign z         = z_q;
    assign err       = err_q;

    // Start fires on the first cycle of each multiply state only.
    assign mm_start = op_state && !issued;

    always_comb begin
        op_state = 1'b0;
        mm_a     = zr_q;
        mm_b     = zr_q;
        unique case (state)
            S_TOM_X: begin
                op_state = 1'b1;
                mm_a     = x_q;
                mm_b     = r2_q;
            end
            S_TOM_1: begin
                op_state = 1'b1;
                mm_a     = ONE;
                mm_b     = r2_q;
            end
            S_SQ: begin
                op_state = 1'b1;
            end
            S_MUL: begin
                op_state = 1'b1;
                mm_b     = p_q;
            end
            S_FROMM: begin
                op_state = 1'b1;
                mm_b     = ONE;
            end
            default: begin
                op_state = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (in_valid) state_nxt = S_CHECK;
            end
            S_CHECK: begin
                if (bad_op || m_one) state_nxt = S_DONE;
                else                 state_nxt = S_TOM_X;
            end
            S_TOM_X: begin
                if (mm_done) state_nxt = S_TOM_1;
            end
            S_TOM_1: begin
                if (mm_done) begin
                    if (len_q == '0) state_nxt = S_FROMM;
                    else             state_nxt = S_SQ;
                end
            end
            S_SQ: begin
                if (mm_done) begin
                    if (e_bit)       state_nxt = S_MUL;
                    else if (i_zero) state_nxt = S_FROMM;
                    else             state_nxt = S_SQ;
                end
            end
            S_MUL: begin
                if (mm_done) begin
                    if (i_zero) state_nxt = S_FROMM;
                    else        state_nxt = S_SQ;
                end
            end
            S_FROMM: begin
                if (mm_done) state_nxt = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q    <= '0;
            e_q    <= '0;
            len_q  <= '0;
            m_q    <= '0;
            r2_q   <= '0;
            p_q    <= '0;
            zr_q   <= '0;
            i_q    <= '0;
            issued <= 1'b0;
            z_q    <= '0;
            err_q  <= ERR_NONE;
        end else begin
            if (mm_start)     issued <= 1'b1;
            else if (mm_done) issued <= 1'b0;

            if (accept) begin
                x_q   <= x;
                e_q   <= e;
                len_q <= exp_len;
                m_q   <= m;
                r2_q  <= r2;
            end

            if (state == S_CHECK) begin
                if (bad_op) begin
                    z_q   <= '0;
                    err_q <= ERR_OPERAND;
                end else if (m_one) begin
                    z_q   <= '0;
                    err_q <= ERR_NONE;
                end
            end

            if (mm_done) begin
                unique case (state)
                    S_TOM_X: begin
                        p_q <= mm_s;
                    end
                    S_TOM_1: begin
                        zr_q <= mm_s;
                        if (len_q != '0) i_q <= len_q - LEN_ONE;
                    end
                    S_SQ: begin
                        zr_q <= mm_s;
                        if (!e_bit && !i_zero) i_q <= i_q - LEN_ONE;
                    end
                    S_MUL: begin
                        zr_q <= mm_s;
                        if (!i_zero) i_q <= i_q - LEN_ONE;
                    end
                    S_FROMM: begin
                        z_q   <= mm_s;
                        err_q <= ERR_NONE;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    mont_mult #(
        .WIDTH (WIDTH)
    ) u_mm (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mm_start),
        .a     (mm_a),
        .b     (mm_b),
        .m     (m_q),
        .done  (mm_done),
        .s     (mm_s)
    );

endmodule

// File: tb/tb_mont_modexp_engine.sv
// Self-checking bench for mont_modexp_engine at WIDTH=16, EXP_WIDTH=16.
// Compares result, error flag and latency against a plain-arithmetic model.
module tb_mont_modexp_engine;

    localparam int W     = 16;
    localparam int EW    = 16;
    localparam int LW    = 5;
    localparam int OPLAT = W + 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  x;
    logic [EW-1:0] e;
    logic [LW-1:0] exp_len;
    logic [W-1:0]  m;
    logic [W-1:0]  r2;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  z;
    logic          err;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    bit pending = 0;
    bit armed = 0;
    logic [W-1:0] exp_z = '0;
    logic         exp_err = 1'b0;
    int           exp_lat = 0;

    mont_modexp_engine #(
        .WIDTH     (W),
        .EXP_WIDTH (EW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .e         (e),
        .exp_len   (exp_len),
        .m         (m),
        .r2        (r2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .err       (err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    function automatic void model(input logic [W-1:0] xx,
                                  input logic [EW-1:0] ee,
                                  input logic [LW-1:0] ll,
                                  input logic [W-1:0] mm,
                                  output logic [W-1:0] zz,
                                  output logic er, output int lat);
        longint r;
        longint mv;
        longint xv;
        int pop;
        zz  = '0;
        lat = 2;
        if (mm[0] == 1'b0 || xx >= mm || int'(ll) > EW) begin
            er = 1'b1;
            return;
        end
        er = 1'b0;
        if (mm == 1) return;
        r   = 1;
        pop = 0;
        mv  = longint'(mm);
        xv  = longint'(xx);
        for (int i = int'(ll) - 1; i >= 0; i--) begin
            r = (r * r) % mv;
            if (ee[i]) begin
                r = (r * xv) % mv;
                pop++;
            end
        end
        zz  = W'(r);
        lat = 2 + (3 + int'(ll) + pop) * OPLAT;
    endfunction

    // Compare process: every cycle the result is presented.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (!armed) begin
                checks++;
                errors++;
                $display("FAIL spurious_out_valid got=1 want=0");
            end else begin
                chk("z", 64'(z), 64'(exp_z));
                chk("err", 64'(err), 64'(exp_err));
                chk("in_ready_while_valid", 64'(in_ready), 64'd0);
                chk("busy_while_valid", 64'(busy), 64'd1);
                if (pending) begin
                    chk("latency", 64'(cyc - acc_cyc), 64'(exp_lat));
                    pending = 0;
                end
                if (out_ready) armed = 0;
            end
        end
    end

    task automatic start_op(input logic [W-1:0] xx, input logic [EW-1:0] ee,
                            input logic [LW-1:0] ll, input logic [W-1:0] mm);
        logic [W-1:0] zz;
        logic er;
        int lat;
        model(xx, ee, ll, mm, zz, er, lat);
        @(negedge clk);
        for (int k = 0; k < 2000 && !in_ready; k++) @(negedge clk);
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout got=0 want=1");
            return;
        end
        in_valid = 1'b1;
        x        = xx;
        e        = ee;
        exp_len  = ll;
        m        = mm;
        r2       = (mm == 0) ? '0 : W'((64'd1 << 32) % 64'(mm));
        @(posedge clk);
        acc_cyc = cyc;
        exp_z   = zz;
        exp_err = er;
        exp_lat = lat;
        pending = 1;
        armed   = 1;
        #1;
        in_valid = 1'b0;
        x        = W'($urandom);
        e        = EW'($urandom);
        exp_len  = LW'($urandom);
        m        = W'($urandom);
        r2       = W'($urandom);
    endtask

    task automatic wait_result(input int budget);
        for (int k = 0; k < budget && pending; k++) @(negedge clk);
        if (pending) begin
            checks++;
            errors++;
            $display("FAIL result_timeout got=none want=out_valid");
            pending = 0;
            armed   = 0;
        end
    endtask

    task automatic run(input logic [W-1:0] xx, input logic [EW-1:0] ee,
                       input logic [LW-1:0] ll, input logic [W-1:0] mm);
        start_op(xx, ee, ll, mm);
        wait_result(1000);
        @(negedge clk);
    endtask

    initial begin
        logic [W-1:0] mz;
        logic me;
        int ml;
        logic [W-1:0] rm;
        logic [W-1:0] rx;
        logic [EW-1:0] re;
        logic [LW-1:0] rl;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        x         = '0;
        e         = '0;
        exp_len   = '0;
        m         = '0;
        r2        = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_z", 64'(z), 64'd0);
        rst_n = 1'b1;

        model(16'd4, 16'd13, 5'd4, 16'd497, mz, me, ml);
        chk("model_case1_z", 64'(mz), 64'd445);
        chk("model_case1_lat", 64'(ml), 64'd192);
        model(16'd3, 16'd5, 5'd16, 16'd7, mz, me, ml);
        chk("model_case2_z", 64'(mz), 64'd5);
        model(16'd3, 16'd0, 5'd0, 16'd7, mz, me, ml);
        chk("model_e0_z", 64'(mz), 64'd1);
        model(16'd5, 16'd1, 5'd1, 16'd1000, mz, me, ml);
        chk("model_even_err", 64'(me), 64'd1);

        run(16'd4, 16'd13, 5'd4, 16'd497);
        run(16'd3, 16'd0, 5'd0, 16'd7);
        run(16'd3, 16'd5, 5'd16, 16'd7);
        run(16'd3, 16'd5, 5'd4, 16'd1000);
        run(16'd600, 16'd5, 5'd4, 16'd497);
        run(16'd0, 16'd5, 5'd4, 16'd1);
        run(16'd3, 16'd5, 5'd20, 16'd7);

        out_ready = 1'b0;
        start_op(16'd4, 16'd13, 5'd4, 16'd497);
        wait_result(1000);
        repeat (50) @(negedge clk);
        chk("stall_out_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release_in_ready", 64'(in_ready), 64'd1);
        chk("release_out_valid", 64'(out_valid), 64'd0);
        run(16'd3, 16'd5, 5'd16, 16'd7);

        start_op(16'd4, 16'd13, 5'd4, 16'd497);
        repeat (64) @(negedge clk);
        rst_n = 1'b0;
        pending = 0;
        armed = 0;
        #1;
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_err", 64'(err), 64'd0);
        chk("midrst_z", 64'(z), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        run(16'd4, 16'd13, 5'd4, 16'd497);

        for (int n = 0; n < 150; n++) begin
            rm = W'($urandom_range(1, 32767) * 2 + 1);
            rx = W'($urandom_range(0, int'(rm) - 1));
            re = EW'($urandom);
            rl = (n % 3 == 0) ? LW'(EW) : LW'($urandom_range(0, EW));
            if (n % 25 == 7) rm = rm + 1'b1;
            if (n % 25 == 13) rx = rm + W'($urandom_range(0, 5));
            if (n % 10 == 4) out_ready = 1'b0;
            start_op(rx, re, rl, rm);
            wait_result(1000);
            if (!out_ready) begin
                repeat ($urandom_range(1, 4)) @(negedge clk);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
            @(negedge clk);
        end

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
